// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline control state encoding and counter width
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam int CNT_W  = 16;
  localparam int FCNT_W = 2;
  localparam int DCNT_W = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/halt sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W        = 3,
  parameter int FLUSH_EXTRA  = 1,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             init,
  input  logic             id_valid,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rs_addr,
  input  logic [REG_W-1:0] id_rt_addr,
  input  logic             id_halt,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd_addr,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             redirect,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             back_stall,
  output logic             halt,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_EXTRA);
  localparam logic [DCNT_W-1:0] DRAIN_INIT = DCNT_W'(DRAIN_CYCLES);
  localparam state_t            AFTER_TB   = (FLUSH_EXTRA > 0) ? FLUSH : RUN;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [FCNT_W-1:0]  r_fcnt;
  logic [FCNT_W-1:0]  w_fcnt_nxt;
  logic [DCNT_W-1:0]  r_dcnt;
  logic [DCNT_W-1:0]  w_dcnt_nxt;
  logic               r_halt;
  logic               w_halt_nxt;
  logic               w_tb;
  logic               w_lu;
  logic               w_hz;
  logic               w_stall_inc;
  logic               w_redir_inc;

  assign w_tb = ex_valid & ex_branch & ex_taken;
  assign w_lu = ex_valid & ex_mem_read & id_valid &
                ((id_uses_rs & (id_rs_addr == ex_rd_addr)) |
                 (id_uses_rt & (id_rt_addr == ex_rd_addr)));
  assign w_hz = id_valid & id_halt;

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_state <= RUN;
      r_fcnt  <= '0;
      r_dcnt  <= '0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_halt  <= w_halt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_dcnt_nxt  = r_dcnt;
    w_halt_nxt  = r_halt;
    w_stall_inc = 1'b0;
    w_redir_inc = 1'b0;
    case (r_state)
      RUN: begin
        if (w_tb) begin
          w_redir_inc = 1'b1;
          w_state_nxt = AFTER_TB;
          w_fcnt_nxt  = FLUSH_INIT;
        end else if (mem_busy || w_lu) begin
          w_stall_inc = 1'b1;
        end else if (w_hz) begin
          w_state_nxt = DRAIN;
          w_dcnt_nxt  = DRAIN_INIT;
        end
      end
      FLUSH: begin
        // EX only holds a bubble here, so a taken branch cannot be real
        if (!mem_busy) begin
          if (r_fcnt <= FCNT_W'(1)) begin
            w_state_nxt = RUN;
            w_fcnt_nxt  = '0;
          end else begin
            w_fcnt_nxt = r_fcnt - FCNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (w_tb) begin
          w_redir_inc = 1'b1;
          w_state_nxt = AFTER_TB;
          w_fcnt_nxt  = FLUSH_INIT;
          w_dcnt_nxt  = '0;
        end else if (!mem_busy) begin
          if (r_dcnt <= DCNT_W'(1)) begin
            w_state_nxt = HALTED;
            w_halt_nxt  = 1'b1;
            w_dcnt_nxt  = '0;
          end else begin
            w_dcnt_nxt = r_dcnt - DCNT_W'(1);
          end
        end
      end
      HALTED: begin
        w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    redirect    = 1'b0;
    back_stall  = mem_busy;
    if (init) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      back_stall  = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_tb) begin
            redirect    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            back_stall  = 1'b1;
          end else if (w_lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end else if (w_hz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
          end
        end
        FLUSH: begin
          pc_write    = ~mem_busy;
          if_id_flush = 1'b1;
        end
        DRAIN: begin
          if (w_tb) begin
            redirect    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
          end
        end
        HALTED: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          back_stall  = 1'b1;
        end
        default: begin
          pc_write = 1'b1;
        end
      endcase
    end
  end

  assign halt    = r_halt;
  assign state_o = r_state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (init),
    .i_clear (1'b0),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk     (clk),
    .rst     (init),
    .i_clear (1'b0),
    .i_inc   (w_redir_inc),
    .o_count (redir_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 3;
  localparam int FE    = 1;
  localparam int DC    = 4;

  logic             clk = 1'b0;
  logic             init;
  logic             id_valid, id_uses_rs, id_uses_rt, id_halt;
  logic [REG_W-1:0] id_rs_addr, id_rt_addr, ex_rd_addr;
  logic             ex_valid, ex_mem_read, ex_branch, ex_taken, mem_busy;
  logic             pc_write, redirect, if_id_write, if_id_flush, id_ex_flush, back_stall, halt;
  logic [1:0]       state_o;
  logic [15:0]      stall_cnt, redir_cnt;
  logic [8:0]       obs;

  int n_pass  = 0;
  int n_total = 0;

  int m_flush, m_drain, m_stall, m_redir;
  bit m_halted;

  always #5 clk = ~clk;

  assign obs = {pc_write, redirect, if_id_write, if_id_flush, id_ex_flush, back_stall, state_o, halt};

  pipeline_hazard_ctrl #(.REG_W(REG_W), .FLUSH_EXTRA(FE), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .init(init),
    .id_valid(id_valid), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_halt(id_halt),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_branch(ex_branch), .ex_taken(ex_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .redirect(redirect), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .back_stall(back_stall),
    .halt(halt), .state_o(state_o), .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
  );

  // Reference: pipeline mode is "flush cycles left", "drain cycles left" or "halted".
  function automatic int m_state();
    if (m_halted) return 3;
    if (m_drain > 0) return 2;
    if (m_flush > 0) return 1;
    return 0;
  endfunction

  function automatic bit f_tb();
    return ex_valid && ex_branch && ex_taken;
  endfunction

  function automatic bit f_lu();
    return ex_valid && ex_mem_read && id_valid &&
           ((id_uses_rs && id_rs_addr == ex_rd_addr) || (id_uses_rt && id_rt_addr == ex_rd_addr));
  endfunction

  // {pc_write, redirect, if_id_write, if_id_flush, id_ex_flush, back_stall, state, halt}
  function automatic logic [8:0] exp_vec();
    logic [5:0] c;
    logic mb;
    mb = mem_busy;
    if (init)                c = 6'b000110;
    else if (m_halted)       c = 6'b000111;
    else if (m_drain > 0)    c = f_tb() ? {5'b11111, mb} : {5'b00010, mb};
    else if (m_flush > 0)    c = {~mb, 4'b0110, mb};
    else if (f_tb())         c = {5'b11111, mb};
    else if (mb)             c = 6'b000001;
    else if (f_lu())         c = 6'b000010;
    else if (id_valid && id_halt) c = 6'b000100;
    else                     c = 6'b101000;
    return {c, 2'(m_state()), m_halted};
  endfunction

  task automatic m_reset();
    m_flush = 0; m_drain = 0; m_stall = 0; m_redir = 0; m_halted = 0;
  endtask

  task automatic m_step();
    if (init) begin
      m_reset();
    end else if (m_halted) begin
      m_halted = 1;
    end else if (m_drain > 0) begin
      if (f_tb()) begin
        if (m_redir < 65535) m_redir++;
        m_drain = 0;
        m_flush = FE;
      end else if (!mem_busy) begin
        if (m_drain == 1) begin m_drain = 0; m_halted = 1; end
        else m_drain--;
      end
    end else if (m_flush > 0) begin
      if (!mem_busy) m_flush--;
    end else if (f_tb()) begin
      if (m_redir < 65535) m_redir++;
      m_flush = FE;
    end else if (mem_busy || f_lu()) begin
      if (m_stall < 65535) m_stall++;
    end else if (id_valid && id_halt) begin
      m_drain = DC;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic clear_in();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_halt = 0;
    id_rs_addr = '0; id_rt_addr = '0; ex_rd_addr = '0;
    ex_valid = 0; ex_mem_read = 0; ex_branch = 0; ex_taken = 0; mem_busy = 0;
  endtask

  task automatic set_lu();
    ex_valid = 1; ex_mem_read = 1; ex_rd_addr = 3'd2;
    id_valid = 1; id_uses_rs = 1; id_rs_addr = 3'd2; id_rt_addr = 3'd5;
  endtask

  task automatic set_tb();
    ex_valid = 1; ex_branch = 1; ex_taken = 1;
  endtask

  task automatic do_reset();
    init = 1;
    m_reset();
    clear_in();
    @(posedge clk);
    #1;
    init = 0;
  endtask

  task automatic test_reset();
    init = 1;
    clear_in();
    m_reset();
    repeat (2) @(posedge clk);
    #3;
    n_total++; if (obs !== 9'b000110_00_0) $display("FAIL reset_forced obs=%b exp=%b", obs, 9'b000110_00_0); else n_pass++;
    n_total++; if ({stall_cnt, redir_cnt} !== 32'd0) $display("FAIL reset_cnt got=%h exp=0", {stall_cnt, redir_cnt}); else n_pass++;
    @(posedge clk);
    #1;
    init = 0;
    #3;
    n_total++; if (obs !== 9'b101000_00_0) $display("FAIL reset_release obs=%b exp=%b", obs, 9'b101000_00_0); else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu();
    #3;
    n_total++; if ({pc_write, id_ex_flush} !== 2'b01) $display("FAIL lu_stall got=%b exp=01", {pc_write, id_ex_flush}); else n_pass++;
    n_total++; if (obs !== exp_vec()) $display("FAIL lu_vec obs=%b exp=%b", obs, exp_vec()); else n_pass++;
    tick();
    ex_valid = 0; ex_mem_read = 0;
    #3;
    n_total++; if ({pc_write, id_ex_flush} !== 2'b10) $display("FAIL lu_after got=%b exp=10", {pc_write, id_ex_flush}); else n_pass++;
    n_total++; if (stall_cnt !== 16'd1) $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); else n_pass++;
    tick();
    ex_valid = 1; ex_mem_read = 1; id_uses_rs = 0; id_uses_rt = 1;
    #3;
    n_total++; if ({pc_write, id_ex_flush} !== 2'b10) $display("FAIL lu_nors got=%b exp=10", {pc_write, id_ex_flush}); else n_pass++;
    tick();
    n_total++; if (stall_cnt !== 16'd1) $display("FAIL lu_nors_cnt got=%0d exp=1", stall_cnt); else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    set_tb();
    #3;
    n_total++; if ({redirect, if_id_flush, id_ex_flush, pc_write} !== 4'b1111) $display("FAIL br_take got=%b exp=1111", {redirect, if_id_flush, id_ex_flush, pc_write}); else n_pass++;
    tick();
    clear_in();
    #3;
    n_total++; if ({state_o, if_id_flush, redirect} !== 4'b0110) $display("FAIL br_flush got=%b exp=0110", {state_o, if_id_flush, redirect}); else n_pass++;
    tick();
    #3;
    n_total++; if ({state_o, if_id_flush} !== 3'b000) $display("FAIL br_back got=%b exp=000", {state_o, if_id_flush}); else n_pass++;
    n_total++; if (redir_cnt !== 16'd1) $display("FAIL br_cnt got=%0d exp=1", redir_cnt); else n_pass++;
    set_tb();
    mem_busy = 1;
    #3;
    n_total++; if (redirect !== 1'b1) $display("FAIL br_busy got=%b exp=1", redirect); else n_pass++;
    n_total++; if (obs !== exp_vec()) $display("FAIL br_busy_vec obs=%b exp=%b", obs, exp_vec()); else n_pass++;
    tick();
    clear_in();
    tick();
    #3;
    n_total++; if ({state_o, redir_cnt} !== 18'd2) $display("FAIL br_busy_cnt got=%h exp=%h", {state_o, redir_cnt}, 18'd2); else n_pass++;
  endtask

  task automatic test_membusy_lu();
    do_reset();
    set_lu();
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #3;
      n_total++; if ({pc_write, back_stall} !== 2'b01) $display("FAIL mb_lu_c%0d got=%b exp=01", i, {pc_write, back_stall}); else n_pass++;
      tick();
    end
    mem_busy = 0;
    #3;
    n_total++; if ({pc_write, id_ex_flush} !== 2'b01) $display("FAIL mb_lu_last got=%b exp=01", {pc_write, id_ex_flush}); else n_pass++;
    tick();
    ex_valid = 0;
    #3;
    n_total++; if (pc_write !== 1'b1) $display("FAIL mb_lu_done got=%b exp=1", pc_write); else n_pass++;
    n_total++; if (stall_cnt !== 16'd4) $display("FAIL mb_lu_cnt got=%0d exp=4", stall_cnt); else n_pass++;
    tick();
  endtask

  task automatic test_halt();
    int first;
    first = -1;
    do_reset();
    id_valid = 1; id_halt = 1;
    #3;
    n_total++; if (obs !== exp_vec()) $display("FAIL halt_hz obs=%b exp=%b", obs, exp_vec()); else n_pass++;
    tick();
    for (int n = 1; n <= 8; n++) begin
      clear_in();
      mem_busy = (n == 2);
      #3;
      n_total++; if (obs !== exp_vec()) $display("FAIL halt_c%0d obs=%b exp=%b", n, obs, exp_vec()); else n_pass++;
      tick();
      if (first < 0 && halt === 1'b1) first = n;
    end
    n_total++; if (first != 5) $display("FAIL halt_latency got=%0d exp=5", first); else n_pass++;
    clear_in();
    set_tb();
    for (int n = 0; n < 4; n++) begin
      #3;
      n_total++; if ({state_o, halt, redirect, pc_write} !== 5'b11100) $display("FAIL halt_hold%0d got=%b exp=11100", n, {state_o, halt, redirect, pc_write}); else n_pass++;
      tick();
    end
  endtask

  task automatic test_drain_branch();
    do_reset();
    id_valid = 1; id_halt = 1;
    tick();
    clear_in();
    #3;
    n_total++; if (state_o !== 2'd2) $display("FAIL dbr_drain got=%0d exp=2", state_o); else n_pass++;
    tick();
    set_tb();
    #3;
    n_total++; if ({redirect, state_o} !== 3'b110) $display("FAIL dbr_redir got=%b exp=110", {redirect, state_o}); else n_pass++;
    tick();
    clear_in();
    #3;
    n_total++; if (state_o !== 2'd1) $display("FAIL dbr_flush got=%0d exp=1", state_o); else n_pass++;
    tick();
    for (int n = 0; n < 6; n++) begin
      #3;
      n_total++; if (obs !== exp_vec()) $display("FAIL dbr_run%0d obs=%b exp=%b", n, obs, exp_vec()); else n_pass++;
      tick();
    end
    n_total++; if ({halt, redir_cnt} !== 17'd1) $display("FAIL dbr_end got=%h exp=1", {halt, redir_cnt}); else n_pass++;
  endtask

  task automatic test_init_async();
    do_reset();
    set_lu();
    tick();
    clear_in();
    set_tb();
    tick();
    clear_in();
    tick();
    id_valid = 1; id_halt = 1;
    tick();
    clear_in();
    tick();
    #1;
    n_total++; if ({state_o, stall_cnt, redir_cnt} !== {2'd2, 16'd1, 16'd1}) $display("FAIL init_pre got=%h exp=%h", {state_o, stall_cnt, redir_cnt}, {2'd2, 16'd1, 16'd1}); else n_pass++;
    #1;
    init = 1;
    m_reset();
    #1;
    n_total++; if (obs !== 9'b000110_00_0) $display("FAIL init_forced obs=%b exp=%b", obs, 9'b000110_00_0); else n_pass++;
    n_total++; if ({stall_cnt, redir_cnt} !== 32'd0) $display("FAIL init_cnt got=%h exp=0", {stall_cnt, redir_cnt}); else n_pass++;
    tick();
    init = 0;
    #3;
    n_total++; if (obs !== exp_vec()) $display("FAIL init_release obs=%b exp=%b", obs, exp_vec()); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      id_valid    = 1'($urandom_range(0, 1));
      id_uses_rs  = 1'($urandom_range(0, 1));
      id_uses_rt  = 1'($urandom_range(0, 1));
      id_rs_addr  = 3'($urandom_range(0, 3));
      id_rt_addr  = 3'($urandom_range(0, 3));
      ex_rd_addr  = 3'($urandom_range(0, 3));
      id_halt     = ($urandom_range(0, 15) == 0);
      ex_valid    = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_branch   = ($urandom_range(0, 3) == 0);
      ex_taken    = 1'($urandom_range(0, 1));
      mem_busy    = ($urandom_range(0, 3) == 0);
      #3;
      n_total++; if (obs !== exp_vec()) $display("FAIL rnd_vec%0d obs=%b exp=%b", n, obs, exp_vec()); else n_pass++;
      n_total++; if ({stall_cnt, redir_cnt} !== {16'(m_stall), 16'(m_redir)}) $display("FAIL rnd_cnt%0d got=%h exp=%h", n, {stall_cnt, redir_cnt}, {16'(m_stall), 16'(m_redir)}); else n_pass++;
      tick();
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_busy = 1;
    repeat (65540) tick();
    #3;
    n_total++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_cnt got=%h exp=ffff", stall_cnt); else n_pass++;
    tick();
    #3;
    n_total++; if (stall_cnt !== 16'(m_stall)) $display("FAIL sat_hold got=%h exp=%h", stall_cnt, 16'(m_stall)); else n_pass++;
    clear_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_membusy_lu();
    test_halt();
    test_drain_branch();
    test_init_async();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/halt sequencer for the 5-stage pipeline. It drives the fetch unit's pc_write and redirect inputs and the IF/ID and ID/EX register controls.
- Detects load-use hazards, squashes wrong-path instructions after a taken branch resolved in EX, freezes the front end on data-memory busy, and drains the pipeline before asserting halt.
- Keeps saturating stall and redirect performance counters.

Parameters:
- REG_W, 3: register address width.
- FLUSH_EXTRA, 1: extra IF/ID squash cycles after a redirect, covering the synchronous instruction ROM latency. Range 0-3.
- DRAIN_CYCLES, 4: cycles to wait after halt decode before asserting halt. Range 1-15.

Ports:
- clk  in  1  system clock, rising edge.
- init  in  1  asynchronous active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
- id_rs_addr, id_rt_addr  in  REG_W each  ID source registers.
- id_halt  in  1  ID instruction is halt.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd_addr  in  REG_W  EX destination register.
- ex_branch  in  1  EX instruction is a branch.
- ex_taken  in  1  branch condition is true.
- mem_busy  in  1  data memory needs another cycle.
- pc_write  out  1  fetch unit may update PC.
- redirect  out  1  drives fetch branch and taken.
- if_id_write  out  1  IF/ID register load enable.
- if_id_flush  out  1  IF/ID loads a bubble.
- id_ex_flush  out  1  ID/EX loads a bubble.
- back_stall  out  1  EX/MEM/WB hold.
- halt  out  1  registered; pipeline halted.
- state_o  out  2  RUN=0, FLUSH=1, DRAIN=2, HALTED=3.
- stall_cnt  out  16  saturating count of front-end stall cycles.
- redir_cnt  out  16  saturating count of redirects.

Behaviour:
- Reset (init high, asynchronous): state=RUN, counters=0, halt=0, drain and flush counters=0.
- While init is high, outputs are forced: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, redirect=0, back_stall=0.
- After release: all control outputs are combinational from state and inputs. halt, state_o and the counters are registered.
- Terms:
  - tb = ex_valid & ex_branch & ex_taken
  - lu = ex_valid & ex_mem_read & id_valid & ((id_uses_rs & id_rs_addr==ex_rd_addr) | (id_uses_rt & id_rt_addr==ex_rd_addr))
  - hz = id_valid & id_halt
- Defaults: pc_write=1, if_id_write=1, flushes=0, redirect=0, back_stall=mem_busy.
- RUN, priority tb > mem_busy > lu > hz:
  - tb: redirect=1, pc_write=1, if_id_flush=1, id_ex_flush=1. redir_cnt increments. Next state is FLUSH with fcnt=FLUSH_EXTRA if FLUSH_EXTRA>0, else RUN. tb wins over a simultaneous mem_busy.
  - mem_busy: pc_write=0, if_id_write=0, back_stall=1. stall_cnt increments.
  - lu: pc_write=0, if_id_write=0, id_ex_flush=1 (one bubble). stall_cnt increments. Lasts exactly 1 cycle because the bubble then occupies EX.
  - hz: pc_write=0, if_id_write=0, if_id_flush=1. Next state DRAIN, dcnt=DRAIN_CYCLES.
- FLUSH:
  - pc_write=1, if_id_flush=1. fcnt decrements each cycle; exit to RUN when fcnt reaches 1.
  - A tb in FLUSH is illegal (EX holds a bubble) and is ignored.
  - mem_busy freezes fcnt, forces pc_write=0, and asserts back_stall.
- DRAIN:
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=0, so older instructions drain.
  - dcnt decrements on cycles without mem_busy. At dcnt==1 with no mem_busy: next state HALTED and halt<=1.
  - A tb in DRAIN means the halt was on the wrong path: perform the RUN tb action and go to FLUSH/RUN, cancelling the drain. halt stays 0.
- HALTED:
  - halt=1, pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, back_stall=1.
  - Only init exits this state.
- Counters: 16-bit, saturate at 0xFFFF, never wrap.
- Reset mid-FLUSH or mid-DRAIN returns to RUN with counters cleared. No pending action survives reset.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state encoding constants (RUN, FLUSH, DRAIN, HALTED) and CNT_W=16. The fetch and decode stages reuse them.
- One sub-module: sat_counter (width parameter, inc, clear) instantiated twice, for stall_cnt and redir_cnt.

Test Plan:
- Load-use: load to r2 in EX, ID reads r2 via rs -> exactly 1 cycle of pc_write=0, id_ex_flush=1; stall_cnt=1. Repeat with id_uses_rs=0 -> no stall.
- Taken branch, FLUSH_EXTRA=1: tb in RUN -> redirect=1 and both flushes that cycle; if_id_flush=1 for one further cycle; back to RUN; redir_cnt=1. Same cycle with mem_busy=1 -> redirect still taken.
- mem_busy held 3 cycles during lu -> pc_write=0 for 3 cycles plus 1 lu cycle after mem_busy drops; stall_cnt=4.
- Halt with DRAIN_CYCLES=4 and one mem_busy cycle mid-drain -> halt rises 5 cycles after hz. state_o goes 0 -> 2 -> 3 and stays until init.
- tb on the second DRAIN cycle -> redirect=1, state goes to FLUSH then RUN, halt never asserts.
- init pulsed mid-DRAIN, asynchronously between clock edges -> state_o=0, halt=0, counters=0 immediately; forced outputs seen while init is high.
